ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the outbound counterpart of the existing keyboard receive path.
- It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable).
- It runs the full request-to-send, bit-shift and acknowledge sequence on the shared open-drain PS2_CLK and PS2_DATA lines.
- It drives the pads through active-low enables only. The top level ties the pads to high-Z or 0.
- `busy` lets the top level gate KeyboardDecoder while a command is in flight.

Parameters:
- INHIBIT_CYCLES, 12000: cycles PS2_CLK is held low before request-to-send (120 us at 100 MHz).
- START_TIMEOUT, 1500000: cycles allowed from clock release to the first device falling edge (15 ms).
- XFER_TIMEOUT, 200000: cycles allowed from the first device falling edge to the ACK edge (2 ms).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- tx_valid  input  1  request to send tx_data; accepted only when tx_ready=1.
- tx_data  input  8  command byte, sent LSB first.
- tx_ready  output  1  high in IDLE only.
- busy  output  1  high in every state other than IDLE.
- tx_done  output  1  one-cycle pulse; device ACK received and both lines idle.
- tx_err  output  1  one-cycle pulse; timeout or missing ACK.
- ps2_clk_in  input  1  raw PS2_CLK pad value.
- ps2_data_in  input  1  raw PS2_DATA pad value.
- ps2_clk_oe  output  1  1 = pull PS2_CLK low, 0 = release.
- ps2_data_oe  output  1  1 = pull PS2_DATA low, 0 = release.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - All outputs 0 except tx_ready=1.
  - Both oe=0 immediately, so lines are released even mid-transfer.
  - Counters and shift register are cleared.
- Input conditioning:
  - ps2_clk_in and ps2_data_in each pass through 2-flop synchronizers.
  - fall = synced clk was 1 last cycle and is 0 now.
  - Effect latency is 3 clk cycles from a pad edge.
- Frame: shift register holds {parity, tx_data}. Parity is odd, i.e. ~^tx_data.
- IDLE:
  - tx_ready=1.
  - On tx_valid: latch the frame, go to INHIBIT, clear the cycle counter.
- INHIBIT:
  - ps2_clk_oe=1, ps2_data_oe=0.
  - Count to INHIBIT_CYCLES-1, then go to RTS.
- RTS (1 cycle):
  - ps2_clk_oe=1, ps2_data_oe=1 (start bit).
  - Next state is WAIT_CLK.
- WAIT_CLK:
  - ps2_clk_oe=0, ps2_data_oe=1.
  - On the first fall: drive bit0 as ps2_data_oe = ~bit, set bit_cnt=1, go to SHIFT.
  - START_TIMEOUT cycles without a fall: go to ERR.
- SHIFT: on each fall, bit_cnt increments.
  - bit_cnt 1..7: drive data bits 1..7.
  - bit_cnt 8: drive parity.
  - bit_cnt 9: release data (stop bit).
  - The following fall (the 11th overall) goes to ACK_CHK.
  - Data changes only on falls, so the device samples on rising edges.
- ACK_CHK:
  - Sample synced data on the same cycle as the fall.
  - Data 0 means ACK: go to WAIT_IDLE.
  - Data 1: go to ERR.
- WAIT_IDLE:
  - Wait until both synced lines are 1, then go to DONE.
  - Timeout still applies.
- Transfer timeout: XFER_TIMEOUT is counted from the first fall and covers SHIFT, ACK_CHK and WAIT_IDLE. Expiry goes to ERR.
- DONE (1 cycle): tx_done=1, then IDLE.
- ERR (1 cycle): tx_err=1, both oe=0, then IDLE.
- tx_done and tx_err are never high together.
- tx_valid while busy is ignored; there is no queuing.
- tx_data changes after acceptance do not affect the frame in flight.
- ps2_clk_oe and ps2_data_oe are registered, with no combinational glitches.
- The block never drives a line high; release (oe=0) is the only high state.
- A fall seen in INHIBIT or RTS is ignored, because the host owns the clock in those states.

Test Plan:
All scenarios use INHIBIT_CYCLES=20, START_TIMEOUT=200 and XFER_TIMEOUT=400. The device model clocks at a period of 40 cycles, samples data on rising edges and pulls data low for ACK on the 11th fall.
1. Send 0xED:
   - ps2_clk_oe is high for exactly 20 cycles, then data_oe rises.
   - The device samples start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1.
   - tx_done pulses once; busy falls in the same cycle tx_ready rises.
2. Send 0x07 and 0xFF: the sampled parity is 0 for 0x07 and 1 for 0xFF.
3. Device never clocks:
   - tx_err pulses 200 cycles after the clock is released.
   - Both oe=0 after the error.
   - tx_done never asserts.
4. Device omits ACK (data stays 1 at the 11th fall): tx_err pulses and there is no tx_done.
5. Assert rst at bit 4 of a transfer:
   - Both oe drop to 0 in the same cycle, asynchronously.
   - After release, tx_ready=1, and a new 0xF4 send completes with tx_done.
6. Pulse tx_valid with 0x55 while busy during a 0xED send: only 0xED is transmitted and exactly one tx_done occurs.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 11-bit shift, ACK check.
// Pads are driven only through active-low enables (oe=1 pulls the line low).
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int START_TIMEOUT  = 1500000,
    parameter int XFER_TIMEOUT   = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int MAX_AB  = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int MAX_CNT = (MAX_AB > XFER_TIMEOUT) ? MAX_AB : XFER_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_WAIT_CLK,
        S_SHIFT,
        S_ACK_CHK,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic [8:0]       shift_reg, shift_next;
    logic             ack_reg, ack_next;
    logic             clk_oe_reg, clk_oe_next;
    logic             data_oe_reg, data_oe_next;
    logic             drive_next;
    logic [1:0]       clk_sync_reg;
    logic [1:0]       data_sync_reg;
    logic             clk_prev_reg;
    logic             clk_s;
    logic             data_s;
    logic             fall;

    assign clk_s  = clk_sync_reg[1];
    assign data_s = data_sync_reg[1];
    assign fall   = clk_prev_reg & ~clk_s;

    // Synchronizers idle high so reset never fabricates a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_reg  <= 2'b11;
            data_sync_reg <= 2'b11;
            clk_prev_reg  <= 1'b1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], ps2_clk_in};
            data_sync_reg <= {data_sync_reg[0], ps2_data_in};
            clk_prev_reg  <= clk_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            ack_reg     <= 1'b0;
            clk_oe_reg  <= 1'b0;
            data_oe_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            ack_reg     <= ack_next;
            clk_oe_reg  <= clk_oe_next;
            data_oe_reg <= data_oe_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        ack_next     = ack_reg;
        drive_next   = data_oe_reg;
        clk_oe_next  = 1'b0;
        data_oe_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (tx_valid) begin
                    shift_next   = {~^tx_data, tx_data};
                    cnt_next     = CNT_ZERO;
                    bit_cnt_next = 4'd0;
                    state_next   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_reg == INH_LAST) begin
                    cnt_next   = CNT_ZERO;
                    state_next = S_RTS;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            S_RTS: begin
                cnt_next   = CNT_ZERO;
                state_next = S_WAIT_CLK;
            end
            S_WAIT_CLK: begin
                if (fall) begin
                    drive_next   = ~shift_reg[0];
                    shift_next   = {1'b1, shift_reg[8:1]};
                    bit_cnt_next = 4'd1;
                    cnt_next     = CNT_ZERO;
                    state_next   = S_SHIFT;
                end else if (cnt_reg == START_LAST) begin
                    state_next = S_ERR;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            S_SHIFT: begin
                if (cnt_reg == XFER_LAST) begin
                    state_next = S_ERR;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                    if (fall) begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg <= 4'd8) begin
                            // shift_reg[0] walks through data bits 1..7, then parity
                            drive_next = ~shift_reg[0];
                            shift_next = {1'b1, shift_reg[8:1]};
                        end else if (bit_cnt_reg == 4'd9) begin
                            drive_next = 1'b0;
                        end else begin
                            ack_next   = data_s;
                            state_next = S_ACK_CHK;
                        end
                    end
                end
            end
            S_ACK_CHK: begin
                if (cnt_reg == XFER_LAST) begin
                    state_next = S_ERR;
                end else begin
                    cnt_next   = cnt_reg + CNT_ONE;
                    state_next = ack_reg ? S_ERR : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (cnt_reg == XFER_LAST) begin
                    state_next = S_ERR;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                    if (clk_s && data_s) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        // Pad enables are decoded from the next state and registered, so they never glitch.
        case (state_next)
            S_INHIBIT: clk_oe_next = 1'b1;
            S_RTS: begin
                clk_oe_next  = 1'b1;
                data_oe_next = 1'b1;
            end
            S_WAIT_CLK: data_oe_next = 1'b1;
            S_SHIFT:    data_oe_next = drive_next;
            default: begin
                clk_oe_next  = 1'b0;
                data_oe_next = 1'b0;
            end
        endcase
    end

    assign ps2_clk_oe  = clk_oe_reg;
    assign ps2_data_oe = data_oe_reg;
    assign tx_ready    = (state_reg == S_IDLE);
    assign busy        = (state_reg != S_IDLE);
    assign tx_done     = (state_reg == S_DONE);
    assign tx_err      = (state_reg == S_ERR);

endmodule
